// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame Pong ball sequencer.
// On each frame tick it queries the edge collision checker and resolves
// bounces, scoring and respawn. It then steps the ball and hands the new
// position to the draw FSM over a req/ack handshake.
// Optional feature macro: BALL_SPEEDUP_EN. When it is defined, the ball
// speeds up after every four top/bottom bounces.
module ball_motion_ctrl #(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 119,
  parameter int SPAWN_X   = 80,
  parameter int SPAWN_Y   = 60,
  parameter int SCORE_MAX = 7
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       gameStart,
  input  logic       frameTick,
  output logic       collEnable,
  input  logic [2:0] collCode,
  input  logic       collDone,
  input  logic       collInner,
  output logic [7:0] xBall,
  output logic [6:0] yBall,
  output logic       dirX,
  output logic       dirY,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic       gameOver,
  output logic       drawReq,
  input  logic       drawAck,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, CHECK, RESOLVE, MOVE, SCORE, DRAW, OVER
  } state_t;

  localparam logic [2:0] CODE_TOP    = 3'b001;
  localparam logic [2:0] CODE_BOTTOM = 3'b011;
  localparam logic [2:0] CODE_LEFT   = 3'b100;
  localparam logic [2:0] CODE_RIGHT  = 3'b010;

  localparam logic signed [9:0] X_MAX_S    = 10'(X_MAX);
  localparam logic signed [8:0] Y_MAX_S    = 9'(Y_MAX);
  localparam logic [3:0]        SCORE_TOP  = 4'(SCORE_MAX);

  state_t     state;
  logic [2:0] codeReg;
  logic       innerReg;
  logic [1:0] step;

`ifdef BALL_SPEEDUP_EN
  logic [1:0] speed;
  logic [1:0] bounceCnt;
  assign step = speed;
`else
  assign step = 2'd1;
`endif

  // Candidate next position. The sums are kept wide enough that a step past
  // either wall is seen as out of range and clamped, so the result never wraps.
  logic signed [9:0] xSum;
  logic signed [8:0] ySum;
  logic [7:0]        xNext;
  logic [6:0]        yNext;

  // Signed step and saturation of the next coordinates
  always_comb begin
    xSum = dirX ? $signed({2'b00, xBall}) + $signed({8'b0, step})
                : $signed({2'b00, xBall}) - $signed({8'b0, step});
    ySum = dirY ? $signed({2'b00, yBall}) + $signed({7'b0, step})
                : $signed({2'b00, yBall}) - $signed({7'b0, step});
    if (xSum < 0)            xNext = 8'd0;
    else if (xSum > X_MAX_S) xNext = 8'(X_MAX);
    else                     xNext = xSum[7:0];
    if (ySum < 0)            yNext = 7'd0;
    else if (ySum > Y_MAX_S) yNext = 7'(Y_MAX);
    else                     yNext = ySum[6:0];
  end

  // Frame sequencer. Every output is registered here together with the state.
  // NOTE: non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (resetn) begin
      // NOTE: reset clears every register, so no handshake survives a mid-frame reset.
      state      <= IDLE;
      xBall      <= 8'(SPAWN_X);
      yBall      <= 7'(SPAWN_Y);
      dirX       <= 1'b1;
      dirY       <= 1'b1;
      scoreL     <= 4'd0;
      scoreR     <= 4'd0;
      collEnable <= 1'b0;
      drawReq    <= 1'b0;
      gameOver   <= 1'b0;
      busy       <= 1'b0;
      codeReg    <= 3'b000;
      innerReg   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      speed      <= 2'd1;
      bounceCnt  <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE, OVER: begin
          if (gameStart) begin
            scoreL   <= 4'd0;
            scoreR   <= 4'd0;
            xBall    <= 8'(SPAWN_X);
            yBall    <= 7'(SPAWN_Y);
            dirX     <= 1'b1;
            dirY     <= 1'b1;
            gameOver <= 1'b0;
            drawReq  <= 1'b1;
            busy     <= 1'b1;
            state    <= DRAW;
`ifdef BALL_SPEEDUP_EN
            speed     <= 2'd1;
            bounceCnt <= 2'd0;
`endif
          end
        end

        WAIT_TICK: begin
          if (frameTick) begin
            collEnable <= 1'b1;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (collDone) begin
            codeReg    <= collCode;
            innerReg   <= collInner;
            collEnable <= 1'b0;
            state      <= RESOLVE;
          end
        end

        RESOLVE: begin
          state <= MOVE;
          case (codeReg)
            CODE_TOP: begin
              dirY <= 1'b1;
              if (innerReg) yBall <= 7'd0;
            end
            CODE_BOTTOM: begin
              dirY <= 1'b0;
              if (innerReg) yBall <= 7'(Y_MAX);
            end
            CODE_LEFT: begin
              if (scoreR != SCORE_TOP) scoreR <= scoreR + 4'd1;
              state <= SCORE;
            end
            CODE_RIGHT: begin
              if (scoreL != SCORE_TOP) scoreL <= scoreL + 4'd1;
              state <= SCORE;
            end
            default: ;
          endcase
`ifdef BALL_SPEEDUP_EN
          if (codeReg == CODE_TOP || codeReg == CODE_BOTTOM) begin
            bounceCnt <= bounceCnt + 2'd1;
            if (bounceCnt == 2'd3 && speed != 2'd3) speed <= speed + 2'd1;
          end
`endif
        end

        MOVE: begin
          xBall   <= xNext;
          yBall   <= yNext;
          drawReq <= 1'b1;
          state   <= DRAW;
        end

        SCORE: begin
`ifdef BALL_SPEEDUP_EN
          speed     <= 2'd1;
          bounceCnt <= 2'd0;
`endif
          if ((codeReg == CODE_LEFT) ? (scoreR == SCORE_TOP) : (scoreL == SCORE_TOP)) begin
            gameOver <= 1'b1;
            busy     <= 1'b0;
            state    <= OVER;
          end else begin
            xBall   <= 8'(SPAWN_X);
            yBall   <= 7'(SPAWN_Y);
            dirX    <= ~dirX;
            drawReq <= 1'b1;
            state   <= DRAW;
          end
        end

        DRAW: begin
          if (drawAck) begin
            drawReq <= 1'b0;
            busy    <= 1'b0;
            state   <= WAIT_TICK;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl. A reference model predicts each
// frame's drawn position, and a monitor compares it when drawReq rises.
module tb_ball_motion_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       gameStart = 1'b0;
  logic       frameTick = 1'b0;
  logic       collEnable;
  logic [2:0] collCode = 3'b000;
  logic       collDone = 1'b0;
  logic       collInner = 1'b0;
  logic [7:0] xBall;
  logic [6:0] yBall;
  logic       dirX, dirY;
  logic [3:0] scoreL, scoreR;
  logic       gameOver, drawReq, busy;
  logic       drawAck = 1'b0;

  ball_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .gameStart(gameStart), .frameTick(frameTick),
    .collEnable(collEnable), .collCode(collCode), .collDone(collDone),
    .collInner(collInner), .xBall(xBall), .yBall(yBall), .dirX(dirX), .dirY(dirY),
    .scoreL(scoreL), .scoreR(scoreR), .gameOver(gameOver), .drawReq(drawReq),
    .drawAck(drawAck), .busy(busy)
  );

  always #5 clock = ~clock;

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Reference model state
  typedef struct { int x; int y; int dx; int dy; int sl; int sr; } snap_t;
  snap_t expQ[$];
  int mX, mY, mDx, mDy, mSL, mSR;
`ifdef BALL_SPEEDUP_EN
  int mSpeed, mBounce;
`endif

  function automatic int clampI(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic modelServe();
    mX = 80; mY = 60; mDx = 1; mDy = 1; mSL = 0; mSR = 0;
`ifdef BALL_SPEEDUP_EN
    mSpeed = 1; mBounce = 0;
`endif
  endtask

  task automatic pushExp();
    snap_t s;
    s.x = mX; s.y = mY; s.dx = mDx; s.dy = mDy; s.sl = mSL; s.sr = mSR;
    expQ.push_back(s);
  endtask

  task automatic modelFrame(input logic [2:0] code, input bit inner, output bit toOver);
    bit scored;
    bit hit;
    int stp;
    scored = 0; hit = 0; toOver = 0;
    case (code)
      3'b001: begin mDy = 1; if (inner) mY = 0; end
      3'b011: begin mDy = 0; if (inner) mY = 119; end
      3'b100: begin if (mSR < 7) mSR++; scored = 1; hit = (mSR == 7); end
      3'b010: begin if (mSL < 7) mSL++; scored = 1; hit = (mSL == 7); end
      default: ;
    endcase
`ifdef BALL_SPEEDUP_EN
    if (code == 3'b001 || code == 3'b011) begin
      if (mBounce == 3 && mSpeed < 3) mSpeed++;
      mBounce = (mBounce + 1) % 4;
    end
    if (scored) begin mSpeed = 1; mBounce = 0; end
    stp = mSpeed;
`else
    stp = 1;
`endif
    if (scored) begin
      if (hit) toOver = 1;
      else begin mX = 80; mY = 60; mDx = 1 - mDx; end
    end else begin
      mX = clampI(mX + (mDx ? stp : -stp), 160);
      mY = clampI(mY + (mDy ? stp : -stp), 119);
    end
  endtask

  // Scoreboard monitor: each rising drawReq consumes one expectation
  snap_t got;
  logic drawPrev = 1'b0;
  always @(negedge clock) begin
    if (drawReq === 1'b1 && drawPrev === 1'b0) begin
      if (expQ.size() == 0) check("unexpectedDraw", 1, 0);
      else begin
        got = expQ.pop_front();
        check("drawX", xBall, got.x);
        check("drawY", yBall, got.y);
        check("drawDirX", dirX, got.dx);
        check("drawDirY", dirY, got.dy);
        check("drawScoreL", scoreL, got.sl);
        check("drawScoreR", scoreR, got.sr);
      end
    end
    drawPrev = drawReq;
  end

  // Wait for a draw request, optionally stall the ack while injecting noise
  task automatic serviceDraw(input int stall);
    int n;
    logic [7:0] hx;
    logic [6:0] hy;
    n = 0;
    while (drawReq !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check("drawSeen", drawReq, 1);
    hx = xBall; hy = yBall;
    for (int i = 0; i < stall; i++) begin
      frameTick = (i % 3 == 0);
      collDone  = i[0];
      collCode  = 3'b100;
      @(negedge clock);
      check("stallReq", drawReq, 1);
      check("stallX", xBall, hx);
      check("stallY", yBall, hy);
    end
    frameTick = 1'b0; collDone = 1'b0; collCode = 3'b000;
    drawAck = 1'b1;
    @(negedge clock);
    drawAck = 1'b0;
    check("drawDrop", drawReq, 0);
    check("idleBusy", busy, 0);
    check("noCheckAfterDraw", collEnable, 0);
  endtask

  task automatic startGame();
    @(negedge clock);
    gameStart = 1'b1;
    modelServe();
    pushExp();
    @(negedge clock);
    gameStart = 1'b0;
    serviceDraw(0);
    check("startScoreL", scoreL, 0);
    check("startScoreR", scoreR, 0);
    check("startOver", gameOver, 0);
  endtask

  // One frame: tick, act as the checker with a given latency, then service
  // the draw (stall < 0 leaves the request unacknowledged).
  task automatic runFrame(input logic [2:0] code, input bit inner, input int lat, input int stall);
    bit toOver;
    int n;
    @(negedge clock);
    frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
    check("collEnOn", collEnable, 1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clock);
      check("collEnHold", collEnable, 1);
    end
    collDone = 1'b1; collCode = code; collInner = inner;
    modelFrame(code, inner, toOver);
    if (!toOver) pushExp();
    @(negedge clock);
    collDone = 1'b0; collCode = 3'($urandom_range(0, 7)); collInner = 1'b0;
    check("collEnOff", collEnable, 0);
    n = 1;
    while (drawReq !== 1'b1 && gameOver !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    collCode = 3'b000;
    if (toOver) check("gameOverSet", gameOver, 1);
    else begin
      check("drawLatency", n, 3);
      if (stall >= 0) serviceDraw(stall);
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_x"}, xBall, 80);
    check({tag, "_y"}, yBall, 60);
    check({tag, "_collEn"}, collEnable, 0);
    check({tag, "_drawReq"}, drawReq, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_over"}, gameOver, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checkResetState("reset");
    check("reset_dirX", dirX, 1);
    check("reset_dirY", dirY, 1);
    check("reset_scoreL", scoreL, 0);
    check("reset_scoreR", scoreR, 0);

    // IDLE ignores frame ticks
    frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
    @(negedge clock);
    check("idleTickIgnored", collEnable, 0);

    startGame();
    runFrame(3'b000, 1'b0, 2, 0);                 // (81,61)
    runFrame(3'b011, 1'b1, 1, 0);                 // bottom wrap, forced to 119, up
    for (int i = 0; i < 118; i++) runFrame(3'b000, 1'b0, i % 3, 0);  // to y=0, x saturates
    runFrame(3'b000, 1'b0, 0, 0);                 // y held at 0
    runFrame(3'b001, 1'b0, 0, 0);                 // top bounce -> y=1
    runFrame(3'b001, 1'b1, 1, 0);                 // wrapped -> forced 0 -> 1

    // Right player scores up to 4
    for (int i = 0; i < 4; i++) runFrame(3'b100, 1'b0, 1, 0);
    check("scoreR4", scoreR, 4);
    // Left player scores to 7 -> OVER
    for (int i = 0; i < 7; i++) runFrame(3'b010, 1'b0, 1, 0);
    check("overScoreL", scoreL, 7);
    check("overScoreR", scoreR, 4);
    check("overBusy", busy, 0);
    frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
    repeat (3) @(negedge clock);
    check("overTickIgnored", collEnable, 0);
    check("overHeld", gameOver, 1);
    startGame();

    // Stalled ack with ticks and stray collDone; then one move per frame
    runFrame(3'b000, 1'b0, 1, 10);
    runFrame(3'b000, 1'b0, 0, 0);

    // Reset during CHECK
    @(negedge clock);
    frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
    check("preResetCollEn", collEnable, 1);
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
    checkResetState("rstCheck");
    startGame();

    // Reset during DRAW of a moved position
    runFrame(3'b000, 1'b0, 1, -1);
    check("drawPending", drawReq, 1);
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
    checkResetState("rstDraw");
    startGame();

    // Four bounces (speed-up point when enabled), then a plain frame
    for (int i = 0; i < 4; i++) runFrame((i % 2) ? 3'b011 : 3'b001, 1'b0, 0, 0);
    runFrame(3'b000, 1'b0, 1, 0);

    repeat (2) @(negedge clock);
    check("queueEmpty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
